// File: rtl/control_pkg.sv
// Shared constants for the microcoded control sequencer: opcodes,
// control-word bit positions and fetch words.
package control_pkg;

  localparam int CW_W = 15;
  typedef logic [CW_W-1:0] cw_t;

  localparam int B_HLT = 14;
  localparam int B_MI  = 13;
  localparam int B_RI  = 12;
  localparam int B_RO  = 11;
  localparam int B_IO  = 10;
  localparam int B_II  = 9;
  localparam int B_AI  = 8;
  localparam int B_AO  = 7;
  localparam int B_EO  = 6;
  localparam int B_SU  = 5;
  localparam int B_BI  = 4;
  localparam int B_OI  = 3;
  localparam int B_CE  = 2;
  localparam int B_CO  = 1;
  localparam int B_J   = 0;

  localparam cw_t CW_HLT = cw_t'(1) << B_HLT;
  localparam cw_t CW_MI  = cw_t'(1) << B_MI;
  localparam cw_t CW_RI  = cw_t'(1) << B_RI;
  localparam cw_t CW_RO  = cw_t'(1) << B_RO;
  localparam cw_t CW_IO  = cw_t'(1) << B_IO;
  localparam cw_t CW_II  = cw_t'(1) << B_II;
  localparam cw_t CW_AI  = cw_t'(1) << B_AI;
  localparam cw_t CW_AO  = cw_t'(1) << B_AO;
  localparam cw_t CW_EO  = cw_t'(1) << B_EO;
  localparam cw_t CW_SU  = cw_t'(1) << B_SU;
  localparam cw_t CW_BI  = cw_t'(1) << B_BI;
  localparam cw_t CW_OI  = cw_t'(1) << B_OI;
  localparam cw_t CW_CE  = cw_t'(1) << B_CE;
  localparam cw_t CW_CO  = cw_t'(1) << B_CO;
  localparam cw_t CW_J   = cw_t'(1) << B_J;

  localparam cw_t CW_FETCH0 = CW_MI | CW_CO;
  localparam cw_t CW_FETCH1 = CW_RO | CW_II | CW_CE;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/control_microcode_rom.sv
// Combinational microcode lookup: (opcode, step, flags) -> control word.
// Conditional jumps decode only when CONTROL_UNIT_COND_JUMP_EN is defined.
module control_microcode_rom
  import control_pkg::*;
(
`ifdef CONTROL_UNIT_COND_JUMP_EN
  input  logic       i_cf,
  input  logic       i_zf,
`endif
  input  logic [3:0] i_op,
  input  logic [2:0] i_step,
  output cw_t        o_cw
);

  always_comb begin
    o_cw = '0;
    case (i_step)
      3'd0: o_cw = CW_FETCH0;
      3'd1: o_cw = CW_FETCH1;
      3'd2: begin
        case (i_op)
          OP_LDA, OP_ADD,
          OP_SUB, OP_STA: o_cw = CW_IO | CW_MI;
          OP_LDI:         o_cw = CW_IO | CW_AI;
          OP_JMP:         o_cw = CW_IO | CW_J;
`ifdef CONTROL_UNIT_COND_JUMP_EN
          OP_JC:  o_cw = i_cf ? (CW_IO | CW_J) : '0;
          OP_JZ:  o_cw = i_zf ? (CW_IO | CW_J) : '0;
`endif
          OP_OUT:         o_cw = CW_AO | CW_OI;
          OP_HLT:         o_cw = CW_HLT;
          default:        o_cw = '0;
        endcase
      end
      3'd3: begin
        case (i_op)
          OP_LDA:         o_cw = CW_RO | CW_AI;
          OP_ADD, OP_SUB: o_cw = CW_RO | CW_BI;
          OP_STA:         o_cw = CW_AO | CW_RI;
          default:        o_cw = '0;
        endcase
      end
      3'd4: begin
        case (i_op)
          OP_ADD:  o_cw = CW_EO | CW_AI;
          OP_SUB:  o_cw = CW_EO | CW_AI | CW_SU;
          default: o_cw = '0;
        endcase
      end
      default: o_cw = '0;
    endcase
  end

endmodule

// File: rtl/tri_state_buffer.sv
// Array of tri-state drivers sharing one enable; releases the net
// to high-Z when disabled.
module tri_state_buffer #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_data,
  input  logic         i_en,
  output wire  [W-1:0] o_data
);

  assign o_data = i_en ? i_data : {W{1'bz}};

endmodule

// File: rtl/control_unit.sv
// Control sequencer: instruction register, microstep counter, bus driver.
// Optional CF/ZF inputs with CONTROL_UNIT_COND_JUMP_EN.
module control_unit
  import control_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CONTROL_UNIT_COND_JUMP_EN
  input  logic       CF,
  input  logic       ZF,
`endif
  inout  wire  [7:0] bus,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       EO,
  output logic       SU,
  output logic       BI,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J
);

  localparam logic [2:0] LAST = 3'(STEPS - 1);

  logic [7:0] r_ir;
  logic [2:0] r_step;
  cw_t        w_rom;
  cw_t        w_cw;

  control_microcode_rom u_rom (
`ifdef CONTROL_UNIT_COND_JUMP_EN
    .i_cf   (CF),
    .i_zf   (ZF),
`endif
    .i_op   (r_ir[7:4]),
    .i_step (r_step),
    .o_cw   (w_rom)
  );

  // Reset gates the word so nothing downstream acts during reset
  assign w_cw = rst ? '0 : w_rom;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir   <= '0;
      r_step <= '0;
    end else begin
      if (w_cw[B_II])
        r_ir <= bus;
      if (!w_cw[B_HLT])
        r_step <= (r_step == LAST) ? 3'd0 : r_step + 3'd1;
    end
  end

  tri_state_buffer #(.W(8)) u_bus_drv (
    .i_data ({4'h0, r_ir[3:0]}),
    .i_en   (w_cw[B_IO]),
    .o_data (bus)
  );

  assign HLT = w_cw[B_HLT];
  assign MI  = w_cw[B_MI];
  assign RI  = w_cw[B_RI];
  assign RO  = w_cw[B_RO];
  assign IO  = w_cw[B_IO];
  assign II  = w_cw[B_II];
  assign AI  = w_cw[B_AI];
  assign AO  = w_cw[B_AO];
  assign EO  = w_cw[B_EO];
  assign SU  = w_cw[B_SU];
  assign BI  = w_cw[B_BI];
  assign OI  = w_cw[B_OI];
  assign CE  = w_cw[B_CE];
  assign CO  = w_cw[B_CO];
  assign J   = w_cw[B_J];

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch, LDA, SUB, JC, reset abort, HLT.
// Expected JC words depend on CONTROL_UNIT_COND_JUMP_EN.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CF  = 1'b0;
  logic       ZF  = 1'b0;
  logic       tb_en = 1'b0;
  logic [7:0] tb_bus = 8'h00;
  wire  [7:0] bus;

  logic HLT, MI, RI, RO, IO, II, AI, AO;
  logic EO, SU, BI, OI, CE, CO, J;

  int errors = 0;
  int checks = 0;

  assign bus = tb_en ? tb_bus : 8'bz;

  control_unit #(.STEPS(5)) dut (
    .clk (clk),
    .rst (rst),
`ifdef CONTROL_UNIT_COND_JUMP_EN
    .CF  (CF),
    .ZF  (ZF),
`endif
    .bus (bus),
    .HLT (HLT), .MI (MI), .RI (RI), .RO (RO), .IO (IO),
    .II  (II),  .AI (AI), .AO (AO), .EO (EO), .SU (SU),
    .BI  (BI),  .OI (OI), .CE (CE), .CO (CO), .J  (J)
  );

  always #5 clk = ~clk;

  // Bench-side word: {HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J}
  wire [14:0] cw = {HLT, MI, RI, RO, IO, II, AI, AO,
                    EO, SU, BI, OI, CE, CO, J};

  localparam logic [14:0] K_HLT = 15'h4000;
  localparam logic [14:0] K_MI  = 15'h2000;
  localparam logic [14:0] K_RI  = 15'h1000;
  localparam logic [14:0] K_RO  = 15'h0800;
  localparam logic [14:0] K_IO  = 15'h0400;
  localparam logic [14:0] K_II  = 15'h0200;
  localparam logic [14:0] K_AI  = 15'h0100;
  localparam logic [14:0] K_AO  = 15'h0080;
  localparam logic [14:0] K_EO  = 15'h0040;
  localparam logic [14:0] K_SU  = 15'h0020;
  localparam logic [14:0] K_BI  = 15'h0010;
  localparam logic [14:0] K_CE  = 15'h0004;
  localparam logic [14:0] K_CO  = 15'h0002;
  localparam logic [14:0] K_J   = 15'h0001;

`ifdef CONTROL_UNIT_COND_JUMP_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_cw", 32'(cw), 32'h0);
    chk("rst_step", 32'(dut.r_step), 32'd0);
    chk("rst_ir", 32'(dut.r_ir), 32'h0);

    rst = 1'b0;
    #1;
    chk("fetch0", 32'(cw), 32'(K_MI | K_CO));
    tick();
    chk("fetch1", 32'(cw), 32'(K_RO | K_II | K_CE));

    // LDA 0xE
    tb_en = 1'b1; tb_bus = 8'h1E;
    tick();
    tb_en = 1'b0;
    #1;
    chk("lda_ir", 32'(dut.r_ir), 32'h1E);
    chk("lda_s2", 32'(cw), 32'(K_IO | K_MI));
    chk("lda_bus", 32'(bus), 32'h0E);
    tick();
    chk("lda_s3", 32'(cw), 32'(K_RO | K_AI));
    tick();
    chk("lda_s4", 32'(cw), 32'h0);
    tick();
    chk("lda_wrap", 32'(cw), 32'(K_MI | K_CO));
    chk("lda_wrap_step", 32'(dut.r_step), 32'd0);

    // SUB 0x5
    tick();
    tb_en = 1'b1; tb_bus = 8'h35;
    tick();
    tb_en = 1'b0;
    #1;
    chk("sub_s2", 32'(cw), 32'(K_IO | K_MI));
    chk("sub_bus", 32'(bus), 32'h05);
    tick();
    chk("sub_s3", 32'(cw), 32'(K_RO | K_BI));
    tick();
    chk("sub_s4", 32'(cw), 32'(K_EO | K_AI | K_SU));
    tick();
    chk("sub_wrap", 32'(cw), 32'(K_MI | K_CO));

    // JC with CF=0
    tick();
    tb_en = 1'b1; tb_bus = 8'h74; CF = 1'b0;
    tick();
    tb_en = 1'b0;
    #1;
    chk("jc0_s2", 32'(cw), 32'h0);
    tick();
    chk("jc0_s3", 32'(cw), 32'h0);
    tick();
    chk("jc0_s4", 32'(cw), 32'h0);
    tick();
    chk("jc0_wrap", 32'(cw), 32'(K_MI | K_CO));

    // JC with CF=1
    tick();
    tb_en = 1'b1; tb_bus = 8'h74; CF = 1'b1;
    tick();
    tb_en = 1'b0;
    #1;
    chk("jc1_s2", 32'(cw), COND ? 32'(K_IO | K_J) : 32'h0);
    if (COND)
      chk("jc1_bus", 32'(bus), 32'h04);
    CF = 1'b0;
    tick();
    tick();
    tick();
    chk("jc1_wrap", 32'(cw), 32'(K_MI | K_CO));

    // STA aborted by reset in step 3
    tick();
    tb_en = 1'b1; tb_bus = 8'h4A;
    tick();
    tb_en = 1'b0;
    #1;
    chk("sta_s2", 32'(cw), 32'(K_IO | K_MI));
    tick();
    chk("sta_s3", 32'(cw), 32'(K_AO | K_RI));
    rst = 1'b1;
    #1;
    chk("sta_rst_now", 32'(cw), 32'h0);
    tick();
    chk("sta_rst_cw", 32'(cw), 32'h0);
    chk("sta_rst_ir", 32'(dut.r_ir), 32'h0);
    chk("sta_rst_step", 32'(dut.r_step), 32'd0);
    rst = 1'b0;
    #1;
    chk("sta_rel", 32'(cw), 32'(K_MI | K_CO));

    // HLT
    tick();
    tb_en = 1'b1; tb_bus = 8'hF0;
    tick();
    tb_en = 1'b0;
    #1;
    chk("hlt_s2", 32'(cw), 32'(K_HLT));
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("hlt_hold", 32'(cw), 32'(K_HLT));
      chk("hlt_step", 32'(dut.r_step), 32'd2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("hlt_exit", 32'(cw), 32'(K_MI | K_CO));
    chk("hlt_exit_step", 32'(dut.r_step), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded control sequencer for the 8-bit computer. It replaces the hand-set DIP control lines with generated control signals. It holds the instruction register and a microstep counter, and decodes opcode plus step into the control word that drives the ALU, RAM, PC and output-display blocks on the shared 8-bit bus. In top it is clocked from `control_clk` (inverted `bus_clk`), so every control word is stable across the rising `bus_clk` edge at which the bus modules latch.

## Interface
- `STEPS`, default 5: microsteps per instruction, legal range 3..8; counter wraps after `STEPS-1`.
- `clk`  in  1  block clock; top connects `control_clk`.
- `rst`  in  1  synchronous, active-high reset.
- `bus`  inout  8  shared main bus; driven only while IO is high.
- `HLT MI RI RO IO II AI AO EO SU BI OI CE CO J`  out  1 each  control lines; each wires to the same-named port of alu/ram/pc/sev_seg_out; `HLT` goes to top.
- `CF`, `ZF`  in  1 each  carry/zero flags from the ALU; present only with `CONTROL_UNIT_COND_JUMP_EN`.

One clock. Reset is synchronous and active-high. Ports are named `clk` and `rst`.

## Operation
- State: `ir[7:0]` and `step[2:0]`.
- The control word is combinational from (`ir[7:4]`, `step`, flags). It is forced to all-zero while `rst` is high.
- Fetch is common to all opcodes:
  - Step 0: MI|CO.
  - Step 1: RO|II|CE.
- Execute steps 2..4 by opcode; any step not listed is all-zero:
  - 0 NOP: nothing.
  - 1 LDA: IO|MI ; RO|AI.
  - 2 ADD: IO|MI ; RO|BI ; EO|AI.
  - 3 SUB: IO|MI ; RO|BI ; EO|AI|SU.
  - 4 STA: IO|MI ; AO|RI.
  - 5 LDI: IO|AI.
  - 6 JMP: IO|J.
  - 7 JC and 8 JZ: see Configuration.
  - 9–D: NOP.
  - E OUT: AO|OI.
  - F HLT: HLT at step 2.
- II: on the clk edge that ends a step in which II is high, `ir <= bus`.
- IO: `bus[3:0] = ir[3:0]` and `bus[7:4] = 0`; bus is high-Z otherwise.
- Step counter:
  - Increments every clk.
  - `STEPS-1` wraps to 0.
  - Holds while HLT is asserted. Only `rst` leaves halt.

## Timing
- `rst` high at a clk edge sets `ir=0` and `step=0`.
- During `rst`: all outputs 0 and bus high-Z.
- First cycle after `rst` falls: MI|CO (opcode 0, step 0).
- Control word changes only after a clk edge. Latency from state change to control word is zero cycles (combinational).
- IR load vs step advance: IR is loaded on the same edge that advances step 1→2. Step 2 therefore decodes the newly fetched opcode.
- One instruction takes exactly `STEPS` clk cycles, including zero-word steps. HLT is the exception.
- `rst` mid-instruction: aborts on that edge; the next cycle is step 0 fetch.
- `rst` and II at the same edge: `rst` wins, `ir=0`.

## Configuration
- `CONTROL_UNIT_COND_JUMP_EN` defined:
  - `CF`/`ZF` ports exist.
  - Opcode 7 JC: step 2 is IO|J if `CF=1`, else all-zero.
  - Opcode 8 JZ: step 2 is IO|J if `ZF=1`, else all-zero.
  - Flags are sampled combinationally during step 2.
- `CONTROL_UNIT_COND_JUMP_EN` undefined: no flag ports; opcodes 7 and 8 decode as NOP.

## Structure
- Shared package `control_pkg` holds:
  - Opcode constants (`OP_NOP`..`OP_HLT`).
  - Control-word bit indices and the 15-bit control-word width.
  - Fetch-step word constants.
- Sub-module `control_microcode_rom`: purely combinational lookup from (opcode, step, flags) to the 15-bit control word.
- The top-level `control_unit` owns `ir`, `step`, reset gating, and the bus driver. The bus driver reuses the existing `tri_state_buffer` array.

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0 and bus Z; release → MI=CO=1 in the first cycle, then RO|II|CE.
- LDA: bus=0x1E during step 1 → `ir`=0x1E; step 2 gives IO|MI with bus=0x0E; step 3 gives RO|AI; step 4 all-zero; step 0 follows.
- SUB opcode 0x3x → step 4 asserts EO, AI and SU together; no other line is high.
- HLT: fetch 0xF0 → HLT=1 at step 2 and stays for 10+ cycles with the step frozen; assert `rst` → step 0, MI|CO.
- JC, macro on:
  - Opcode 0x74 with CF=0 → step 2 all-zero.
  - Opcode 0x74 with CF=1 → IO|J with bus=0x04.
  - Macro off → NOP for both CF values.
- Reset mid-STA: assert `rst` at step 3 (AO|RI) → next cycle all-zero; after release, `ir`=0 and step 0.
